// File: rtl/sprite_drawer_if.sv
// sprite_drawer_if: start/position, sprite RAM read and VGA plot signals of the sprite drawer.
interface sprite_drawer_if;
    logic       start;
    logic [7:0] x_pos;
    logic [6:0] y_pos;
    logic [9:0] ram_addr;
    logic [2:0] ram_colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;
    modport master (
        output start, x_pos, y_pos, ram_colour,
        input  ram_addr, vga_x, vga_y, vga_colour, plot, busy, done
    );
    modport slave (
        input  start, x_pos, y_pos, ram_colour,
        output ram_addr, vga_x, vga_y, vga_colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_drawer.sv
// sprite_drawer: reads a sprite from RAM in raster order and plots it at a screen offset, skipping transparent and off-screen pixels.
module sprite_drawer #(
    parameter int         SPRITE_W      = 20,
    parameter int         SPRITE_H      = 40,
    parameter int         RD_LATENCY    = 2,
    parameter int         TRANSP_EN     = 1,
    parameter logic [2:0] TRANSP_COLOUR = 3'b000,
    parameter int         SCREEN_W      = 160,
    parameter int         SCREEN_H      = 120
) (
    input logic           clk,
    input logic           reset,
    sprite_drawer_if.slave bus
);
    localparam int N  = SPRITE_W * SPRITE_H;
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam int LW = $clog2(RD_LATENCY + 1);
    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;
    state_t                             state_q, state_d;
    logic [9:0]                         addr_q, addr_d;
    logic [CW-1:0]                      col_q, col_d;
    logic [RW-1:0]                      row_q, row_d;
    logic [LW-1:0]                      cnt_q, cnt_d;
    logic [7:0]                         xl_q, xl_d;
    logic [6:0]                         yl_q, yl_d;
    logic [RD_LATENCY-1:0]              vld_q;
    logic [RD_LATENCY-1:0][CW-1:0]      colp_q;
    logic [RD_LATENCY-1:0][RW-1:0]      rowp_q;
    logic [8:0]                         sum_x;
    logic [7:0]                         sum_y;
    logic                               vld, opaque;
    logic                               last_col;
    assign last_col = col_q == CW'(SPRITE_W - 1);
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        xl_d    = xl_q;
        yl_d    = yl_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = DRAW;
                addr_d  = '0;
                col_d   = '0;
                row_d   = '0;
                xl_d    = bus.x_pos;
                yl_d    = bus.y_pos;
            end
            DRAW: if (addr_q == 10'(N - 1)) begin
                state_d = FLUSH;
                cnt_d   = '0;
            end else begin
                addr_d = addr_q + 10'd1;
                col_d  = last_col ? '0 : col_q + 1'b1;
                row_d  = last_col ? row_q + 1'b1 : row_q;
            end
            FLUSH: if (cnt_q == LW'(RD_LATENCY - 1)) state_d = DONE;
                   else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            xl_q    <= '0;
            yl_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            xl_q    <= xl_d;
            yl_q    <= yl_d;
        end
    end
    // coordinates travel alongside the RAM read so they line up with ram_colour
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            colp_q <= '0;
            rowp_q <= '0;
        end else begin
            vld_q[0]  <= state_q == DRAW;
            colp_q[0] <= col_q;
            rowp_q[0] <= row_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                colp_q[i] <= colp_q[i-1];
                rowp_q[i] <= rowp_q[i-1];
            end
        end
    end
    assign vld            = vld_q[RD_LATENCY-1];
    assign sum_x          = {1'b0, xl_q} + 9'(colp_q[RD_LATENCY-1]);
    assign sum_y          = {1'b0, yl_q} + 8'(rowp_q[RD_LATENCY-1]);
    assign opaque         = !(TRANSP_EN != 0 && bus.ram_colour == TRANSP_COLOUR);
    assign bus.plot       = vld && opaque && sum_x < 9'(SCREEN_W) && sum_y < 8'(SCREEN_H);
    assign bus.vga_x      = vld ? sum_x[7:0] : '0;
    assign bus.vga_y      = vld ? sum_y[6:0] : '0;
    assign bus.vga_colour = vld ? bus.ram_colour : '0;
    assign bus.ram_addr   = addr_q;
    assign bus.busy       = state_q == DRAW || state_q == FLUSH;
    assign bus.done       = state_q == DONE;
endmodule

// File: tb/tb_sprite_drawer.sv
// tb_sprite_drawer: table-driven draws checked against a per-pixel scoreboard, plus reset corner cases.
module tb_sprite_drawer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_drawer_if ifc();
    sprite_drawer_if ifn();
    sprite_drawer u_dut (.clk(clk), .reset(reset), .bus(ifc));
    sprite_drawer #(.TRANSP_EN(0)) u_nt (.clk(clk), .reset(reset), .bus(ifn));
    assign ifn.start      = ifc.start;
    assign ifn.x_pos      = ifc.x_pos;
    assign ifn.y_pos      = ifc.y_pos;
    assign ifn.ram_colour = ifc.ram_colour;

    typedef struct {int cyc; logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
    typedef struct {logic [7:0] x; logic [6:0] y; int mode; int inj; int rst; int exp0; int exp1; int exp_done;} vec_t;

    pix_t sb[$];
    vec_t vecs[7];
    int n_cmp = 0, n_bad = 0;
    int rel = 0, mode = 0, plot0, plot1, busy_n, done_n, done_cyc;
    bit armed = 1'b0;
    logic [9:0] a_q;

    function automatic logic [2:0] colour_of(int m, logic [9:0] a);
        return m == 0 ? (a[2:0] | 3'b001) : m == 1 ? (a[0] ? 3'b100 : 3'b000) : 3'b111;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", name, act, exp, rel);
        end
    endtask

    // sprite RAM model: registered address then registered data
    always @(posedge clk) begin
        a_q            <= ifc.ram_addr;
        ifc.ram_colour <= colour_of(mode, a_q);
    end

    always @(posedge clk) begin
        pix_t e;
        logic [31:0] act;
        #1;
        if (armed) begin
            rel++;
            if (rel == 1) chk("addr0", 32'(ifc.ram_addr), 0);
            if (ifc.plot) begin
                plot0++;
                act = {rel[13:0], ifc.vga_x, ifc.vga_y, ifc.vga_colour};
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pix: unexpected plot %0h", act);
                end else begin
                    e = sb.pop_front();
                    chk("pix", act, {e.cyc[13:0], e.x, e.y, e.c});
                end
            end
            if (ifn.plot) plot1++;
            if (ifc.busy) busy_n++;
            if (ifc.done) begin
                done_n++;
                done_cyc = rel;
            end
        end
    end

    task automatic fill(vec_t v);
        int col, row, sx, sy;
        logic [2:0] c;
        sb.delete();
        for (int k = 0; k < 800; k++) begin
            col = k % 20;
            row = k / 20;
            c   = colour_of(v.mode, 10'(k));
            sx  = int'(v.x) + col;
            sy  = int'(v.y) + row;
            if (c != 3'b000 && sx < 160 && sy < 120 && (v.rst == 0 || 3 + k <= v.rst))
                sb.push_back('{3 + k, sx[7:0], sy[6:0], c});
        end
    endtask

    task automatic do_draw(vec_t v);
        @(negedge clk);
        mode = v.mode;
        fill(v);
        plot0 = 0; plot1 = 0; busy_n = 0; done_n = 0; done_cyc = 0;
        rel = 0;
        armed = 1'b1;
        ifc.x_pos = v.x;
        ifc.y_pos = v.y;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        while (rel < 1000 && !(v.rst == 0 && done_n > 0)) begin
            ifc.start = v.inj != 0 && rel == v.inj;
            if (ifc.start) ifc.x_pos = 8'd0;
            reset = v.rst != 0 && rel == v.rst;
            if (v.rst != 0 && rel == v.rst + 1)
                chk("abort", 32'({ifc.plot, ifc.busy, ifc.ram_addr}), 0);
            @(negedge clk);
        end
        ifc.start = 1'b0;
        reset = 1'b0;
        chk("plots", plot0, v.exp0);
        chk("plots_opaque_build", plot1, v.exp1);
        chk("done_cycle", done_cyc, v.exp_done);
        chk("done_count", done_n, v.exp_done != 0 ? 1 : 0);
        chk("busy_cycles", busy_n, v.rst != 0 ? v.rst : 802);
        chk("sb_left", sb.size(), 0);
    endtask

    initial begin
        vecs[0] = '{8'd10,  7'd5,   0, 0,   0,   800, 800, 803};
        vecs[1] = '{8'd0,   7'd0,   1, 0,   0,   400, 800, 803};
        vecs[2] = '{8'd150, 7'd100, 2, 400, 0,   200, 200, 803};
        vecs[3] = '{8'd159, 7'd119, 0, 0,   0,   1,   1,   803};
        vecs[4] = '{8'd140, 7'd80,  0, 0,   0,   800, 800, 803};
        vecs[5] = '{8'd10,  7'd5,   0, 0,   300, 298, 298, 0};
        vecs[6] = '{8'd0,   7'd0,   2, 0,   0,   800, 800, 803};
        reset = 1'b1;
        ifc.start = 1'b0;
        ifc.x_pos = 8'd0;
        ifc.y_pos = 7'd0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 32'({ifc.plot, ifc.busy, ifc.done, ifc.ram_addr}), 0);
        chk("reset_vga", 32'({ifc.vga_x, ifc.vga_y, ifc.vga_colour}), 0);
        reset = 1'b0;
        foreach (vecs[i]) do_draw(vecs[i]);
        @(negedge clk);
        ifc.start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wins", 32'({ifc.busy, ifc.plot, ifc.ram_addr}), 0);
        ifc.start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wins_idle", 32'({ifc.busy, ifc.done}), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
